// File: rtl/prog_timer_pkg.sv
// prog_timer_pkg: shared constants and types for the programmable timer.
// Holds the register map (per-channel offsets, channel stride, STATUS
// offset), the CTRL bit positions and the counting-mode encoding.
package prog_timer_pkg;

    // Address distance between consecutive channel register blocks.
    localparam int unsigned CH_STRIDE = 8;

    // Offset of the global STATUS register from BASE_ADDR.
    localparam logic [23:0] STATUS_OFF = 24'h20;

    // Register offsets inside one channel block.
    typedef enum logic [2:0] {
        REG_CTRL      = 3'd0,
        REG_PSC       = 3'd1,
        REG_PRESET_LO = 3'd2,
        REG_PRESET_HI = 3'd3,
        REG_CMP_LO    = 3'd4,
        REG_CMP_HI    = 3'd5,
        REG_COUNT_LO  = 3'd6,
        REG_COUNT_HI  = 3'd7
    } reg_e;

    // CTRL bit positions.
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_CLR   = 1;
    localparam int unsigned CTRL_MODE  = 2;
    localparam int unsigned CTRL_IRQEN = 3;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

endpackage

// File: rtl/prog_timer_channel.sv
// prog_timer_channel: one timer channel (prescaler, up-counter with preset
// wrap, compare detect, one-shot stop) plus its CTRL/PSC/PRESET/CMP storage.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   tick_in               256 Hz time-base pulse
//   *_we, wdata           byte write strobes from the top-level decoder
//   count_lo_rd           COUNT lo read strobe, snapshots COUNT hi
//   ctrl_rd .. latch_hi   register read-back values (zero-extended to 16)
//   irq_en                CTRL irq-enable bit
//   ovf_evt, cmp_evt      one-cycle event pulses for the STATUS register
//   count                 live counter value
module prog_timer_channel
    import prog_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             ctrl_we,
    input  logic             psc_we,
    input  logic             preset_lo_we,
    input  logic             preset_hi_we,
    input  logic             cmp_lo_we,
    input  logic             cmp_hi_we,
    input  logic [7:0]       wdata,
    input  logic             count_lo_rd,
    output logic [7:0]       ctrl_rd,
    output logic [7:0]       psc_rd,
    output logic [15:0]      preset_rd,
    output logic [15:0]      cmp_rd,
    output logic [15:0]      count_rd,
    output logic [7:0]       latch_hi,
    output logic             irq_en,
    output logic             ovf_evt,
    output logic             cmp_evt,
    output logic [WIDTH-1:0] count
);

    logic             enable;
    mode_e            mode;
    logic [7:0]       psc;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] cmp;
    logic [7:0]       prescale;

    logic [7:0]       mask;
    logic             clear_wr;
    logic             step;
    logic             wrap;
    logic [WIDTH-1:0] count_next;

    assign ctrl_rd   = {4'b0000, irq_en, (mode == MODE_ONESHOT), 1'b0, enable};
    assign psc_rd    = psc;
    assign preset_rd = 16'(preset);
    assign cmp_rd    = 16'(cmp);
    assign count_rd  = 16'(count);

    always_comb begin
        mask       = ~(8'hFF << psc[2:0]);
        clear_wr   = ctrl_we && wdata[CTRL_CLR];
        // A clear write cancels any step in the same cycle, so no event fires.
        step       = tick_in && enable && ((prescale & mask) == mask) && !clear_wr;
        // Hitting the all-ones ceiling also wraps: covers PRESET moved below count.
        wrap       = (count == preset) || (count == '1);
        count_next = wrap ? '0 : count + WIDTH'(1);
        ovf_evt    = step && wrap;
        cmp_evt    = step && (count_next == cmp);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            mode     <= MODE_PERIODIC;
            irq_en   <= 1'b0;
            psc      <= '0;
            preset   <= '1;
            cmp      <= '0;
            count    <= '0;
            prescale <= '0;
            latch_hi <= '0;
        end else begin
            if (ctrl_we) begin
                enable <= wdata[CTRL_EN];
                mode   <= mode_e'(wdata[CTRL_MODE]);
                irq_en <= wdata[CTRL_IRQEN];
            end else if (ovf_evt && (mode == MODE_ONESHOT)) begin
                enable <= 1'b0;
            end

            if (psc_we)
                psc <= wdata;
            if (preset_lo_we)
                preset <= WIDTH'({preset_rd[15:8], wdata});
            if (preset_hi_we && (WIDTH > 8))
                preset <= WIDTH'({wdata, preset_rd[7:0]});
            if (cmp_lo_we)
                cmp <= WIDTH'({cmp_rd[15:8], wdata});
            if (cmp_hi_we && (WIDTH > 8))
                cmp <= WIDTH'({wdata, cmp_rd[7:0]});

            if (clear_wr) begin
                count    <= '0;
                prescale <= '0;
            end else begin
                if (tick_in && enable)
                    prescale <= prescale + 8'd1;
                if (step)
                    count <= count_next;
            end

            if (count_lo_rd)
                latch_hi <= count_rd[15:8];
        end
    end

endmodule

// File: rtl/prog_timer.sv
// prog_timer: multi-channel programmable timer with a byte-wide register bus.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   tick_in                    256 Hz time-base pulse (clk domain)
//   bus_write, bus_read        single-cycle access strobes
//   bus_address_in, bus_data_in 24-bit address, 8-bit write data
//   bus_data_out               combinational read data (0 when unmapped)
//   irq                        per channel {compare, overflow} pending & enable
//   count_out                  live counter values, channel 0 in the LSBs
module prog_timer
    import prog_timer_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned WIDTH     = 16,
    parameter logic [23:0] BASE_ADDR = 24'h2040
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick_in,
    input  logic                    bus_write,
    input  logic                    bus_read,
    input  logic [23:0]             bus_address_in,
    input  logic [7:0]              bus_data_in,
    output logic [7:0]              bus_data_out,
    output logic [2*NUM_CH-1:0]     irq,
    output logic [NUM_CH*WIDTH-1:0] count_out
);

    localparam logic [23:0] CH_SPAN = 24'(CH_STRIDE * NUM_CH);

    logic [23:0]         offset;
    logic                ch_hit;
    logic                status_hit;
    logic [1:0]          ch_idx;
    reg_e                reg_idx;

    logic [2*NUM_CH-1:0] status;
    logic [2*NUM_CH-1:0] set_mask;
    logic [2*NUM_CH-1:0] clr_mask;

    logic [7:0]          ctrl_rd   [NUM_CH];
    logic [7:0]          psc_rd    [NUM_CH];
    logic [15:0]         preset_rd [NUM_CH];
    logic [15:0]         cmp_rd    [NUM_CH];
    logic [15:0]         count_rd  [NUM_CH];
    logic [7:0]          latch_hi  [NUM_CH];

    // Addresses below BASE_ADDR wrap to a large offset and decode as unmapped.
    assign offset     = bus_address_in - BASE_ADDR;
    assign ch_hit     = offset < CH_SPAN;
    assign status_hit = offset == STATUS_OFF;
    assign ch_idx     = offset[4:3];
    assign reg_idx    = reg_e'(offset[2:0]);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel;
        logic irq_en;
        logic ovf_evt;
        logic cmp_evt;

        assign sel = ch_hit && (ch_idx == 2'(c));

        prog_timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .tick_in      (tick_in),
            .ctrl_we      (bus_write && sel && (reg_idx == REG_CTRL)),
            .psc_we       (bus_write && sel && (reg_idx == REG_PSC)),
            .preset_lo_we (bus_write && sel && (reg_idx == REG_PRESET_LO)),
            .preset_hi_we (bus_write && sel && (reg_idx == REG_PRESET_HI)),
            .cmp_lo_we    (bus_write && sel && (reg_idx == REG_CMP_LO)),
            .cmp_hi_we    (bus_write && sel && (reg_idx == REG_CMP_HI)),
            .wdata        (bus_data_in),
            .count_lo_rd  (bus_read && sel && (reg_idx == REG_COUNT_LO)),
            .ctrl_rd      (ctrl_rd[c]),
            .psc_rd       (psc_rd[c]),
            .preset_rd    (preset_rd[c]),
            .cmp_rd       (cmp_rd[c]),
            .count_rd     (count_rd[c]),
            .latch_hi     (latch_hi[c]),
            .irq_en       (irq_en),
            .ovf_evt      (ovf_evt),
            .cmp_evt      (cmp_evt),
            .count        (count_out[c*WIDTH +: WIDTH])
        );

        assign set_mask[2*c]   = ovf_evt;
        assign set_mask[2*c+1] = cmp_evt;
        assign irq[2*c]        = status[2*c] && irq_en;
        assign irq[2*c+1]      = status[2*c+1] && irq_en;
    end

    assign clr_mask = (bus_write && status_hit) ? bus_data_in[2*NUM_CH-1:0] : '0;

    // Set is OR-ed in after the clear so a same-cycle event wins.
    always_ff @(posedge clk) begin
        if (reset)
            status <= '0;
        else
            status <= (status & ~clr_mask) | set_mask;
    end

    always_comb begin
        bus_data_out = '0;
        if (status_hit) begin
            bus_data_out = 8'(status);
        end else if (ch_hit) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 2'(c)) begin
                    case (reg_idx)
                        REG_CTRL:      bus_data_out = ctrl_rd[c];
                        REG_PSC:       bus_data_out = psc_rd[c];
                        REG_PRESET_LO: bus_data_out = preset_rd[c][7:0];
                        REG_PRESET_HI: bus_data_out = preset_rd[c][15:8];
                        REG_CMP_LO:    bus_data_out = cmp_rd[c][7:0];
                        REG_CMP_HI:    bus_data_out = cmp_rd[c][15:8];
                        REG_COUNT_LO:  bus_data_out = count_rd[c][7:0];
                        REG_COUNT_HI:  bus_data_out = latch_hi[c];
                        default:       bus_data_out = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: self-checking bench for prog_timer (NUM_CH=2, WIDTH=16).
// Expected values are queued when stimulus is applied and compared when
// the corresponding DUT output is observed.
module tb_prog_timer;

    localparam logic [23:0] BASE   = 24'h2040;
    localparam logic [23:0] STATUS = BASE + 24'h20;

    logic        clk;
    logic        reset;
    logic        tick_in;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic [3:0]  irq;
    logic [31:0] count_out;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    prog_timer #(
        .NUM_CH   (2),
        .WIDTH    (16),
        .BASE_ADDR(BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick_in       (tick_in),
        .bus_write     (bus_write),
        .bus_read      (bus_read),
        .bus_address_in(bus_address_in),
        .bus_data_in   (bus_data_in),
        .bus_data_out  (bus_data_out),
        .irq           (irq),
        .count_out     (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic observe(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: got 0x%0h expected no pending entry", got);
        end else begin
            check_eq(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    function automatic logic [23:0] ch_a(input int unsigned c, input int unsigned off);
        return BASE + 24'(8 * c + off);
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        bus_address_in = a;
        bus_data_in    = d;
        bus_write      = 1'b1;
        cyc();
        bus_write      = 1'b0;
    endtask

    task automatic tick_wr(input logic [23:0] a, input logic [7:0] d);
        bus_address_in = a;
        bus_data_in    = d;
        bus_write      = 1'b1;
        tick_in        = 1'b1;
        cyc();
        bus_write      = 1'b0;
        tick_in        = 1'b0;
    endtask

    task automatic tick();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
    endtask

    task automatic rd_obs(input logic [23:0] a);
        logic [7:0] d;
        bus_address_in = a;
        bus_read       = 1'b1;
        #2 d = bus_data_out;
        cyc();
        bus_read = 1'b0;
        observe(32'(d));
    endtask

    initial begin
        logic [15:0] seq35 [5];
        seq35[0] = 16'd1; seq35[1] = 16'd2; seq35[2] = 16'd3;
        seq35[3] = 16'd0; seq35[4] = 16'd1;

        reset = 1'b1; tick_in = 1'b0; bus_write = 1'b0; bus_read = 1'b0;
        bus_address_in = '0; bus_data_in = '0;
        @(negedge clk);
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state
        expect_val("rst_count", 32'h0);        observe(count_out);
        expect_val("rst_irq", 32'h0);          observe(32'(irq));
        expect_val("rst_ctrl0", 32'h00);       rd_obs(ch_a(0, 0));
        expect_val("rst_preset_lo", 32'hFF);   rd_obs(ch_a(0, 2));
        expect_val("rst_preset_hi1", 32'hFF);  rd_obs(ch_a(1, 3));
        expect_val("rst_status", 32'h00);      rd_obs(STATUS);
        expect_val("unmapped_hi", 32'h00);     rd_obs(STATUS + 24'h1);
        expect_val("unmapped_lo", 32'h00);     rd_obs(BASE - 24'h1);

        // Periodic count 1,2,3,0,1 with PRESET=3; CMP=0 also fires on the wrap
        wr(ch_a(0, 2), 8'h03);
        wr(ch_a(0, 3), 8'h00);
        wr(ch_a(0, 0), 8'h01);
        for (int i = 0; i < 5; i++) begin
            expect_val($sformatf("s35_cnt%0d", i), 32'(seq35[i]));
            tick();
            observe(32'(count_out[15:0]));
            if (i == 2) begin
                expect_val("s35_status_pre", 32'h00); rd_obs(STATUS);
            end
            if (i == 3) begin
                expect_val("s35_status_ovf", 32'h03); rd_obs(STATUS);
            end
        end
        wr(ch_a(0, 0), 8'h02);
        wr(STATUS, 8'hFF);
        expect_val("s35_cleared", 32'h0); observe(count_out);

        // Channel 1 divide-by-4, compare at 2 with interrupt
        wr(ch_a(1, 1), 8'h02);
        wr(ch_a(1, 4), 8'h02);
        wr(ch_a(1, 0), 8'h09);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 4) begin
                expect_val("s36_cnt4", 32'd1); observe(32'(count_out[31:16]));
            end
            if (i == 7) begin
                expect_val("s36_irq7", 32'h0); observe(32'(irq));
            end
        end
        expect_val("s36_cnt8", 32'd2);  observe(32'(count_out[31:16]));
        expect_val("s36_irq3", 32'h8);  observe(32'(irq));
        wr(STATUS, 8'h08);
        expect_val("s36_irq_clr", 32'h0); observe(32'(irq));
        wr(ch_a(1, 0), 8'h02);

        // One-shot with PRESET=1: 1,0,0 and enable drops
        wr(ch_a(0, 2), 8'h01);
        wr(ch_a(0, 0), 8'h05);
        expect_val("s37_c1", 32'd1); tick(); observe(32'(count_out[15:0]));
        expect_val("s37_c2", 32'd0); tick(); observe(32'(count_out[15:0]));
        expect_val("s37_c3", 32'd0); tick(); observe(32'(count_out[15:0]));
        expect_val("s37_ctrl", 32'h04); rd_obs(ch_a(0, 0));

        // Clear write coincident with an overflow-causing step at count=5
        wr(STATUS, 8'hFF);
        wr(ch_a(0, 0), 8'h02);
        wr(ch_a(0, 2), 8'h05);
        wr(ch_a(0, 0), 8'h01);
        for (int i = 0; i < 5; i++) tick();
        expect_val("s38_cnt5", 32'd5);   observe(32'(count_out[15:0]));
        tick_wr(ch_a(0, 0), 8'h03);
        expect_val("s38_cnt0", 32'd0);   observe(32'(count_out[15:0]));
        expect_val("s38_status", 32'h00); rd_obs(STATUS);
        wr(ch_a(0, 0), 8'h02);

        // Coherent 16-bit read across a lo->hi carry
        wr(ch_a(0, 2), 8'hFF);
        wr(ch_a(0, 3), 8'hFF);
        wr(ch_a(0, 0), 8'h01);
        for (int i = 0; i < 255; i++) tick();
        expect_val("s39_cnt_ff", 32'h00FF);  observe(32'(count_out[15:0]));
        expect_val("s39_lo", 32'hFF);        rd_obs(ch_a(0, 6));
        tick();
        expect_val("s39_cnt_100", 32'h0100); observe(32'(count_out[15:0]));
        expect_val("s39_hi_latched", 32'h00); rd_obs(ch_a(0, 7));
        expect_val("s39_lo2", 32'h00);       rd_obs(ch_a(0, 6));
        expect_val("s39_hi2", 32'h01);       rd_obs(ch_a(0, 7));

        // Overflow in the same cycle as a STATUS clear: set wins
        wr(ch_a(0, 2), 8'h01);
        wr(ch_a(0, 3), 8'h01);
        tick();
        expect_val("s40_cnt", 32'h0101); observe(32'(count_out[15:0]));
        tick_wr(STATUS, 8'h01);
        expect_val("s40_wrap", 32'h0);    observe(32'(count_out[15:0]));
        expect_val("s40_status", 32'h03); rd_obs(STATUS);

        // Reset overrides a simultaneous write and step
        tick();
        reset = 1'b1;
        tick_wr(ch_a(0, 2), 8'h10);
        reset = 1'b0;
        expect_val("rst2_count", 32'h0);     observe(count_out);
        expect_val("rst2_irq", 32'h0);       observe(32'(irq));
        expect_val("rst2_preset", 32'hFF);   rd_obs(ch_a(0, 2));
        expect_val("rst2_status", 32'h00);   rd_obs(STATUS);

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
